// File: rtl/pt_pair_writer.sv
// Buffers filtered pixels in a small FIFO and writes horizontally adjacent
// pixel pairs to memory as one packed word, throttling the upstream source.
module pt_pair_writer #(
  parameter int DEPTH       = 8,
  parameter int LOG_DEPTH   = 3,
  parameter int SLACK       = 4,
  parameter int PIX_W       = 18,
  parameter int MEM_W       = 36,
  parameter int IMAGE_WIDTH = 640
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             frame_flag,
  output logic             request,
  input  logic [PIX_W-1:0] pixel,
  input  logic [9:0]       x_in,
  input  logic [8:0]       y_in,
  input  logic             pixel_flag,
  output logic             pt_flag,
  output logic             pt_wr,
  output logic [9:0]       pt_x,
  output logic [8:0]       pt_y,
  output logic [MEM_W-1:0] pt_pixel_write,
  output logic [1:0]       pt_mask,
  input  logic             done_pt,
  output logic             overflow,
  output logic [1:0]       dbg_state_o
);

  // Handshakes: every cycle with pixel_flag high carries one entry (request is
  // flow control with SLACK entries of headroom, not a per-beat ready). pt_flag
  // rises with a stable word and holds until the cycle done_pt is seen high.
  localparam int CNT_W = LOG_DEPTH + 1;
  localparam int ENT_W = 19 + PIX_W;
  localparam logic [CNT_W-1:0] FULL_C      = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] REQ_LIM_C   = CNT_W'(DEPTH - SLACK);
  localparam logic [9:0]       LAST_EVEN_X = 10'(IMAGE_WIDTH - 2);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    WRITE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [ENT_W-1:0]     mem_q [DEPTH];
  logic [LOG_DEPTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [LOG_DEPTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [LOG_DEPTH-1:0] rd_nxt;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 request_q, request_d;
  logic                 overflow_q, overflow_d;
  logic [9:0]           pt_x_q, pt_x_d;
  logic [8:0]           pt_y_q, pt_y_d;
  logic [MEM_W-1:0]     data_q, data_d;
  logic [1:0]           mask_q, mask_d;
  logic [1:0]           pop_cnt;
  logic                 push, full;
  logic [PIX_W-1:0]     h_pix, s_pix;
  logic [9:0]           h_x, s_x;
  logic [8:0]           h_y, s_y;
  logic                 pair_ok, hold_wait;

  assign full   = (count_q == FULL_C);
  assign push   = pixel_flag && !frame_flag && !full;
  assign rd_nxt = rd_ptr_q + LOG_DEPTH'(1);

  assign {h_y, h_x, h_pix} = mem_q[rd_ptr_q];
  assign {s_y, s_x, s_pix} = mem_q[rd_nxt];

  assign pair_ok   = (count_q >= CNT_W'(2)) && (s_y == h_y) && (s_x == h_x + 10'd1);
  // An even head waits for its partner, except the last even column whose
  // partner may never come before the row ends.
  assign hold_wait = !h_x[0] && (count_q == CNT_W'(1)) && (h_x != LAST_EVEN_X);

  always_comb begin
    state_d = state_q;
    pop_cnt = 2'd0;
    pt_x_d  = pt_x_q;
    pt_y_d  = pt_y_q;
    data_d  = data_q;
    mask_d  = mask_q;
    case (state_q)
      IDLE: begin
        if (!frame_flag && (count_q != '0)) state_d = FETCH;
      end
      FETCH: begin
        if (frame_flag) begin
          state_d = IDLE;
        end else if (!hold_wait) begin
          state_d = WRITE;
          pt_x_d  = {h_x[9:1], 1'b0};
          pt_y_d  = h_y;
          if (h_x[0]) begin
            pop_cnt = 2'd1;
            mask_d  = 2'b01;
            data_d  = {{PIX_W{1'b0}}, h_pix};
          end else if (pair_ok) begin
            pop_cnt = 2'd2;
            mask_d  = 2'b11;
            data_d  = {h_pix, s_pix};
          end else begin
            pop_cnt = 2'd1;
            mask_d  = 2'b10;
            data_d  = {h_pix, {PIX_W{1'b0}}};
          end
        end
      end
      WRITE: begin
        if (done_pt) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q | (pixel_flag && !frame_flag && full);
    request_d  = (count_q <= REQ_LIM_C) && !frame_flag;
    if (frame_flag) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + LOG_DEPTH'(1);
      rd_ptr_d = rd_ptr_q + LOG_DEPTH'(pop_cnt);
      count_d  = count_q + CNT_W'(push) - CNT_W'(pop_cnt);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      request_q  <= 1'b0;
      overflow_q <= 1'b0;
      pt_x_q     <= '0;
      pt_y_q     <= '0;
      data_q     <= '0;
      mask_q     <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      request_q  <= request_d;
      overflow_q <= overflow_d;
      pt_x_q     <= pt_x_d;
      pt_y_q     <= pt_y_d;
      data_q     <= data_d;
      mask_q     <= mask_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= {y_in, x_in, pixel};
  end

  assign request        = request_q;
  assign overflow       = overflow_q;
  assign pt_flag        = (state_q == WRITE);
  assign pt_wr          = (state_q == WRITE);
  assign pt_x           = pt_x_q;
  assign pt_y           = pt_y_q;
  assign pt_pixel_write = data_q;
  assign pt_mask        = mask_q;
  assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_pt_pair_writer.sv
// Self-checking bench for pt_pair_writer: table of short pixel streams,
// randomized streams against a pairing model, and hand-written corner cases.
module tb_pt_pair_writer;

  localparam int IMG_W = 640;
  localparam int NCASE = 9;
  localparam int NRAND = 60;

  logic        clock = 1'b0;
  logic        reset, frame_flag, request, pixel_flag;
  logic [17:0] pixel;
  logic [9:0]  x_in, pt_x;
  logic [8:0]  y_in, pt_y;
  logic        pt_flag, pt_wr, done_pt, overflow;
  logic [35:0] pt_pixel_write;
  logic [1:0]  pt_mask, dbg_state;
  logic        done_auto, done_man;

  assign done_pt = done_auto | done_man;

  pt_pair_writer dut (
    .clock(clock), .reset(reset), .frame_flag(frame_flag), .request(request),
    .pixel(pixel), .x_in(x_in), .y_in(y_in), .pixel_flag(pixel_flag),
    .pt_flag(pt_flag), .pt_wr(pt_wr), .pt_x(pt_x), .pt_y(pt_y),
    .pt_pixel_write(pt_pixel_write), .pt_mask(pt_mask), .done_pt(done_pt),
    .overflow(overflow), .dbg_state_o(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [56:0] exp_q[$];
  bit          auto_done = 1'b1;
  int          done_delay = 2;

  typedef struct packed {
    logic [8:0]  y;
    logic [9:0]  x;
    logic [17:0] p;
  } pix_t;

  typedef struct {
    int               n;
    int               nw;
    logic [3:0][9:0]  xs;
    logic [3:0][8:0]  ys;
    logic [3:0][17:0] ps;
    logic [3:0][56:0] ew;
  } vec_t;

  vec_t tbl[NCASE];
  pix_t stim[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [56:0] wr(input int x, input int y, input logic [1:0] m,
                                     input logic [35:0] d);
    return {x[9:0], y[8:0], m, d};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_pix(input logic [9:0] x, input logic [8:0] y, input logic [17:0] p);
    pixel_flag = 1'b1;
    x_in       = x;
    y_in       = y;
    pixel      = p;
    @(negedge clock);
    pixel_flag = 1'b0;
  endtask

  task automatic wait_flag(input string name);
    int t;
    t = 0;
    while (!pt_flag && t < 50) begin
      @(negedge clock);
      t++;
    end
    check({name, "_pt_flag_seen"}, pt_flag, 1);
  endtask

  task automatic wait_drain(input string name);
    int t;
    bit seen;
    t = 0;
    while ((exp_q.size() != 0 || pt_flag) && t < 600) begin
      @(negedge clock);
      t++;
    end
    check({name, "_pending_writes"}, exp_q.size(), 0);
    seen = 1'b0;
    repeat (8) begin
      @(negedge clock);
      if (pt_flag) seen = 1'b1;
    end
    check({name, "_no_extra_write"}, seen, 0);
  endtask

  task automatic add_pix(input int k, input int x, input int y, input logic [17:0] p);
    tbl[k].xs[tbl[k].n] = x[9:0];
    tbl[k].ys[tbl[k].n] = y[8:0];
    tbl[k].ps[tbl[k].n] = p;
    tbl[k].n++;
  endtask

  task automatic add_wr(input int k, input logic [56:0] w);
    tbl[k].ew[tbl[k].nw] = w;
    tbl[k].nw++;
  endtask

  // Pairing rules: odd head alone; even head pairs with an immediately
  // following x+1 pixel on the same row; otherwise even head alone. A final
  // unmatched even pixel waits (except the last even column).
  task automatic model_expect();
    int   i;
    pix_t h, s;
    i = 0;
    while (i < stim.size()) begin
      h = stim[i];
      if (h.x % 2 == 1) begin
        exp_q.push_back(wr(int'(h.x) - 1, h.y, 2'b01, {18'd0, h.p}));
        i++;
      end else if (i + 1 < stim.size() && stim[i+1].y == h.y && stim[i+1].x == h.x + 1) begin
        s = stim[i+1];
        exp_q.push_back(wr(h.x, h.y, 2'b11, {h.p, s.p}));
        i += 2;
      end else if (i + 1 < stim.size() || h.x == IMG_W - 2) begin
        exp_q.push_back(wr(h.x, h.y, 2'b10, {h.p, 18'd0}));
        i++;
      end else begin
        i = stim.size();
      end
    end
  endtask

  // ---------------- memory responder / write checker ----------------
  initial begin : responder
    logic [56:0] got, e;
    int          d;
    done_auto = 1'b0;
    forever begin
      @(negedge clock);
      if (auto_done && pt_flag && !reset) begin
        got = {pt_x, pt_y, pt_mask, pt_pixel_write};
        check("pt_wr_follows_flag", pt_wr, 1);
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_write: got 0x%0h, expected no write", got);
        end else begin
          e = exp_q.pop_front();
          check("write_word", got, e);
        end
        d = (done_delay < 0) ? $urandom_range(0, 3) : done_delay;
        repeat (d) @(negedge clock);
        check("write_held", {pt_flag, pt_x, pt_y, pt_mask, pt_pixel_write}, {1'b1, got});
        done_auto = 1'b1;
        @(negedge clock);
        done_auto = 1'b0;
        check("flag_drops_after_done", pt_flag, 0);
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin : main
    pix_t cur, prev;
    int   t, k;
    bit   seen;

    reset = 1'b1; frame_flag = 1'b0; pixel_flag = 1'b0;
    pixel = '0; x_in = '0; y_in = '0; done_man = 1'b0;

    for (int i = 0; i < NCASE; i++) begin
      tbl[i].n = 0;
      tbl[i].nw = 0;
      tbl[i].xs = '0; tbl[i].ys = '0; tbl[i].ps = '0; tbl[i].ew = '0;
    end
    add_pix(0, 0, 5, 18'h0A001); add_pix(0, 1, 5, 18'h0B002);
    add_pix(0, 2, 5, 18'h0C003); add_pix(0, 3, 5, 18'h0D004);
    add_wr(0, wr(0, 5, 2'b11, {18'h0A001, 18'h0B002}));
    add_wr(0, wr(2, 5, 2'b11, {18'h0C003, 18'h0D004}));
    add_pix(1, 7, 1, 18'h3FFFF);
    add_wr(1, wr(6, 1, 2'b01, {18'h00000, 18'h3FFFF}));
    add_pix(2, 4, 2, 18'h12345); add_pix(2, 5, 3, 18'h2ABCD);
    add_wr(2, wr(4, 2, 2'b10, {18'h12345, 18'h00000}));
    add_wr(2, wr(4, 3, 2'b01, {18'h00000, 18'h2ABCD}));
    add_pix(3, 638, 0, 18'h15555);
    add_wr(3, wr(638, 0, 2'b10, {18'h15555, 18'h00000}));
    add_pix(4, 10, 4, 18'h01111); add_pix(4, 13, 4, 18'h02222);
    add_wr(4, wr(10, 4, 2'b10, {18'h01111, 18'h00000}));
    add_wr(4, wr(12, 4, 2'b01, {18'h00000, 18'h02222}));
    add_pix(5, 639, 479, 18'h2AAAA);
    add_wr(5, wr(638, 479, 2'b01, {18'h00000, 18'h2AAAA}));
    add_pix(6, 638, 7, 18'h03333); add_pix(6, 639, 7, 18'h04444);
    add_wr(6, wr(638, 7, 2'b11, {18'h03333, 18'h04444}));
    add_pix(7, 100, 3, 18'h05555); add_pix(7, 101, 4, 18'h06666);
    add_wr(7, wr(100, 3, 2'b10, {18'h05555, 18'h00000}));
    add_wr(7, wr(100, 4, 2'b01, {18'h00000, 18'h06666}));
    add_pix(8, 8, 6, 18'h07777); add_pix(8, 9, 6, 18'h08888); add_pix(8, 11, 6, 18'h09999);
    add_wr(8, wr(8, 6, 2'b11, {18'h07777, 18'h08888}));
    add_wr(8, wr(10, 6, 2'b01, {18'h00000, 18'h09999}));

    // Reset values
    @(negedge clock);
    check("rst_request", request, 0);
    check("rst_pt_flag", pt_flag, 0);
    check("rst_pt_wr", pt_wr, 0);
    check("rst_pt_x", pt_x, 0);
    check("rst_pt_y", pt_y, 0);
    check("rst_data", pt_pixel_write, 0);
    check("rst_mask", pt_mask, 0);
    check("rst_overflow", overflow, 0);
    reset = 1'b0;
    @(negedge clock);
    check("request_after_reset", request, 1);

    // Table-driven streams
    for (int c = 0; c < NCASE; c++) begin
      done_delay = 2;
      for (int j = 0; j < tbl[c].nw; j++) exp_q.push_back(tbl[c].ew[j]);
      for (int i = 0; i < tbl[c].n; i++) drive_pix(tbl[c].xs[i], tbl[c].ys[i], tbl[c].ps[i]);
      wait_drain($sformatf("case%0d", c));
      check($sformatf("case%0d_overflow", c), overflow, 0);
      check($sformatf("case%0d_request", c), request, 1);
    end

    // Randomized stream obeying request, checked against the pairing model
    prev = '0;
    for (int i = 0; i < NRAND; i++) begin
      if (i > 0 && !prev.x[0] && $urandom_range(0, 2) != 0) begin
        cur.x = prev.x + 10'd1;
        cur.y = prev.y;
      end else begin
        cur.x = ($urandom_range(0, 15) == 0) ? 10'd639 : 10'($urandom_range(0, 637));
        cur.y = ($urandom_range(0, 3) == 0) ? prev.y : 9'($urandom_range(0, 479));
      end
      if (i == NRAND - 1) cur.x[0] = 1'b1;
      cur.p = 18'($urandom);
      stim.push_back(cur);
      prev = cur;
    end
    model_expect();
    done_delay = -1;
    for (int i = 0; i < NRAND; i++) begin
      t = 0;
      while (!request && t < 300) begin
        @(negedge clock);
        t++;
      end
      check("rand_request_wait", request, 1);
      drive_pix(stim[i].x, stim[i].y, stim[i].p);
      repeat ($urandom_range(0, 2)) @(negedge clock);
    end
    wait_drain("random");
    check("random_overflow", overflow, 0);

    // Throttle and overflow with done_pt held low
    auto_done = 1'b0;
    drive_pix(10'd1, 9'd0, 18'h00001);
    wait_flag("ovf_first");
    for (k = 1; k <= 8; k++) begin
      pixel_flag = 1'b1;
      x_in = 10'(2 * k + 1); y_in = 9'd0; pixel = 18'(k);
      @(negedge clock);
      check($sformatf("throttle_req_k%0d", k), request, (k - 1) <= 4);
      check($sformatf("throttle_ovf_k%0d", k), overflow, 0);
    end
    x_in = 10'd19;
    @(negedge clock);
    pixel_flag = 1'b0;
    check("overflow_set", overflow, 1);
    check("request_low_when_full", request, 0);
    repeat (3) @(negedge clock);
    check("overflow_sticky", overflow, 1);

    // frame_flag during WRITE: write still completes, FIFO emptied
    frame_flag = 1'b1;
    @(negedge clock);
    frame_flag = 1'b0;
    check("wflush_write_pending", pt_flag, 1);
    check("wflush_request_forced", request, 0);
    check("wflush_word_x", pt_x, 0);
    check("wflush_word_mask", pt_mask, 2'b01);
    done_man = 1'b1;
    @(negedge clock);
    done_man = 1'b0;
    check("wflush_flag_drop", pt_flag, 0);
    seen = 1'b0;
    repeat (8) begin
      @(negedge clock);
      if (pt_flag) seen = 1'b1;
    end
    check("wflush_fifo_empty", seen, 0);
    check("wflush_overflow_kept", overflow, 1);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("overflow_cleared_by_reset", overflow, 0);
    @(negedge clock);

    // frame_flag during FETCH with three entries queued
    drive_pix(10'd1, 9'd9, 18'h00F01);
    wait_flag("fflush_first");
    drive_pix(10'd3, 9'd9, 18'h00F03);
    drive_pix(10'd5, 9'd9, 18'h00F05);
    drive_pix(10'd7, 9'd9, 18'h00F07);
    check("fflush_first_word", {pt_x, pt_y, pt_mask, pt_pixel_write},
          wr(0, 9, 2'b01, {18'd0, 18'h00F01}));
    done_man = 1'b1;
    @(negedge clock);
    done_man = 1'b0;
    t = 0;
    while (dbg_state != 2'd1 && t < 6) begin
      @(negedge clock);
      t++;
    end
    check("fflush_in_fetch", dbg_state, 1);
    frame_flag = 1'b1;
    @(negedge clock);
    frame_flag = 1'b0;
    check("fflush_back_to_idle", dbg_state, 0);
    seen = 1'b0;
    repeat (8) begin
      @(negedge clock);
      if (pt_flag) seen = 1'b1;
    end
    check("fflush_no_write", seen, 0);
    check("fflush_request", request, 1);
    auto_done = 1'b1;
    done_delay = 1;
    exp_q.push_back(wr(8, 9, 2'b01, {18'd0, 18'h00F09}));
    drive_pix(10'd9, 9'd9, 18'h00F09);
    wait_drain("fflush_after");

    // Asynchronous reset in the middle of a write
    auto_done = 1'b0;
    drive_pix(10'd7, 9'd1, 18'h1F00F);
    wait_flag("rst_mid");
    #2 reset = 1'b1;
    #1;
    check("rstmid_pt_flag", pt_flag, 0);
    check("rstmid_pt_wr", pt_wr, 0);
    check("rstmid_pt_x", pt_x, 0);
    check("rstmid_pt_y", pt_y, 0);
    check("rstmid_data", pt_pixel_write, 0);
    check("rstmid_mask", pt_mask, 0);
    check("rstmid_request", request, 0);
    @(negedge clock);
    reset = 1'b0;
    t = 0;
    while (!request && t < 2) begin
      @(negedge clock);
      t++;
    end
    check("rstmid_request_returns", request, 1);
    auto_done = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pt_pair_writer.md
Name: pt_pair_writer

Overview:
- Consumer stage directly downstream of the low-pass-filter pixel source.
- Drives the source's `request` line and accepts its pixel/x/y/pixel_flag stream into a small FIFO.
- Packs horizontally adjacent pixel pairs into one memory word and writes them through the memory interface's projective-transform write port with a flag/done handshake.
- Sits between the filtered-pixel stage and memory_interface; it throttles the upstream source so no pixel is dropped.

Parameters:
- DEPTH, 8, FIFO entries; power of two.
- LOG_DEPTH, 3, log2(DEPTH).
- SLACK, 4, minimum free entries required to keep `request` high; covers upstream pipeline latency.
- PIX_W, 18, pixel width; equals `LOG_TRUNC.
- MEM_W, 36, memory word width; must equal 2*PIX_W (`LOG_MEM).

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- frame_flag  in  1  start-of-frame pulse; flushes the stage
- request  out  1  level request to the upstream pixel source
- pixel  in  PIX_W  upstream pixel data
- x_in  in  10  upstream pixel x
- y_in  in  9  upstream pixel y
- pixel_flag  in  1  one-cycle valid strobe for pixel/x_in/y_in
- pt_flag  out  1  memory write request; held until done_pt
- pt_wr  out  1  write enable; equals pt_flag
- pt_x  out  10  word-aligned x (bit0 always 0)
- pt_y  out  9  row
- pt_pixel_write  out  MEM_W  packed data: even-x pixel in [MEM_W-1:PIX_W], odd-x pixel in [PIX_W-1:0]
- pt_mask  out  2  half-word enables: [1] upper (even) half, [0] lower (odd) half
- done_pt  in  1  memory acknowledges write (one-cycle pulse)
- overflow  out  1  sticky error flag; pixel_flag seen while FIFO full

Behaviour:
- Reset (async) clears: FIFO pointers/count, FSM=IDLE, request=0, pt_flag=0, pt_x=0, pt_y=0, pt_pixel_write=0, pt_mask=0, overflow=0.
- FIFO:
  - Entry = {y,x,pixel}, 37 bits.
  - Push on pixel_flag when count<DEPTH.
  - Push while full: data dropped, overflow<=1. overflow clears only on reset.
  - Push and pop in the same cycle: count unchanged.
- request: registered; 1 when count <= DEPTH-SLACK and frame_flag=0, else 0. Updates one cycle after count changes.
- Drain FSM, states IDLE, FETCH, WRITE:
  - IDLE: if count>=1, go to FETCH.
  - FETCH (one cycle): examine the head entry H.
    - Pair case: H.x even, count>=2, and the second entry S has S.y==H.y and S.x==H.x+1. Pop both; mask=2'b11; data={H.pix,S.pix}.
    - Odd case: H.x odd. Pop one; mask=2'b01; data={PIX_W'0,H.pix}.
    - Lone even case: H.x even and S does not match. Pop one; mask=2'b10; data={H.pix,PIX_W'0}.
    - H.x even and count==1: stay in FETCH without popping until a second entry arrives or frame_flag. Exception: H.x==`IMAGE_WIDTH-2 is never waited on when unpaired; it is written lone.
    - Registers pt_x={H.x[9:1],1'b0} and pt_y=H.y, then goes to WRITE.
  - WRITE: pt_flag=pt_wr=1; outputs held stable. On done_pt, deassert next cycle and return to IDLE.
  - Minimum 3 cycles per word.
- frame_flag:
  - Flushes FIFO (count=0, pointers=0) and forces request=0 that cycle.
  - In IDLE/FETCH, FSM goes to IDLE with no write issued.
  - In WRITE, the write completes normally (waits for done_pt) to keep the memory handshake legal, then returns to IDLE.
  - pixel_flag coincident with frame_flag is discarded.
- done_pt outside WRITE is ignored.
- Widths: x+1 compare is done at 10 bits; no wrap, since x<=`IMAGE_WIDTH-1.

Test Plan:
- Reset mid-WRITE (pt_flag=1) -> all outputs 0 immediately; request returns 1 within 2 cycles of reset release.
- Stream x=0..3, y=5, done_pt returned 2 cycles after each pt_flag -> two writes: (pt_x=0,pt_y=5,mask=11,data={p0,p1}), then (pt_x=2,mask=11,data={p2,p3}); no overflow.
- Single pixel x=7,y=1 -> one write pt_x=6, mask=01, upper half 0.
- Pixels x=4 (y=2) then x=5 (y=3) -> two lone writes: (pt_x=4,y=2,mask=10), then (pt_x=4,y=3,mask=01).
- Hold done_pt low, push 8 pixels with continuous pixel_flag -> request drops once count reaches 5; 9th strobe while full sets overflow=1, which stays 1.
- frame_flag during FETCH with 3 entries queued -> no write, count=0; frame_flag during WRITE -> write completes on done_pt, FIFO empty afterward.
